// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the serial sequence
// detectors. One word of buffering (hold register) in front of a WIDTH-bit
// shifter; each word leaves MSB-first, one bit per clock, on seq.
//
// Handshake (din side): a transfer happens at a rising edge where
// din_valid & din_ready are both high. din_ready depends only on register
// state (hold register empty), never combinationally on din_valid, so the
// producer may hold din_valid high and simply wait for din_ready. The
// producer must keep din/din_len stable while din_valid is high and
// din_ready is low; data is sampled only on the transfer edge.

module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [LEN_W-1:0] din_len,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             seq,
    output logic             seq_valid,
    output logic             last,
    output logic             busy,
    output logic [7:0]       word_cnt,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO_L   = LEN_W'(2);

    state_t           state;
    logic [WIDTH-1:0] hold_data;
    logic [LEN_W-1:0] hold_len;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] cnt;

    logic [LEN_W-1:0] norm_len;
    logic [WIDTH-1:0] aligned;
    logic             accept;

    // Normalise the requested length and left-align the word so its first
    // bit to send sits at the shifter MSB; bits above len-1 fall off the top.
    always_comb begin
        norm_len = din_len;
        if (din_len == '0 || din_len > WIDTH_L) begin
            norm_len = WIDTH_L;
        end
        aligned = din << (WIDTH_L - norm_len);
        accept  = din_valid && !hold_full;
    end

    assign din_ready = !hold_full;
    assign busy      = (state == SHIFT) || hold_full;
    assign state_dbg = state;

    // Hold register fill, shifter control and registered serial outputs.
    // A load always empties the hold register, and an accept needs it empty,
    // so the two never happen on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_len  <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            seq       <= 1'b0;
            seq_valid <= 1'b0;
            last      <= 1'b0;
            word_cnt  <= 8'd0;
        end else begin
            if (accept) begin
                hold_full <= 1'b1;
                hold_data <= aligned;
                hold_len  <= norm_len;
            end

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state     <= SHIFT;
                        hold_full <= 1'b0;
                        shreg     <= hold_data;
                        cnt       <= hold_len;
                        seq       <= hold_data[WIDTH-1];
                        seq_valid <= 1'b1;
                        last      <= (hold_len == ONE_L);
                    end else begin
                        seq       <= 1'b0;
                        seq_valid <= 1'b0;
                        last      <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (cnt == ONE_L) begin
                        // Final bit retires; chain straight into the next
                        // word if one is waiting, otherwise fall idle.
                        word_cnt <= word_cnt + 8'd1;
                        if (hold_full) begin
                            hold_full <= 1'b0;
                            shreg     <= hold_data;
                            cnt       <= hold_len;
                            seq       <= hold_data[WIDTH-1];
                            seq_valid <= 1'b1;
                            last      <= (hold_len == ONE_L);
                        end else begin
                            state     <= IDLE;
                            shreg     <= '0;
                            cnt       <= '0;
                            seq       <= 1'b0;
                            seq_valid <= 1'b0;
                            last      <= 1'b0;
                        end
                    end else begin
                        shreg     <= shreg << 1;
                        cnt       <= cnt - ONE_L;
                        seq       <= shreg[WIDTH-2];
                        seq_valid <= 1'b1;
                        last      <= (cnt == TWO_L);
                    end
                end

                default: begin
                    state     <= IDLE;
                    seq       <= 1'b0;
                    seq_valid <= 1'b0;
                    last      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: random and directed words, expected bit stream
// built from the word/length rules into a queue and compared to what
// appears on seq/last while seq_valid is high.

module tb_seq_serializer;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [LEN_W-1:0] din_len = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             seq;
    logic             seq_valid;
    logic             last;
    logic             busy;
    logic [7:0]       word_cnt;
    logic             state_dbg;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_len   (din_len),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .seq       (seq),
        .seq_valid (seq_valid),
        .last      (last),
        .busy      (busy),
        .word_cnt  (word_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         first_v  = -1;
    int         last_v   = -1;
    int         xfer_cnt = 0;
    int         exp_cnt  = 0;
    logic [1:0] obs_q[$];   // {seq, last} per valid bit
    logic [1:0] exp_q[$];

    // Transfers counted at the active edge (pre-edge handshake values).
    always @(posedge clk) begin
        if (rst && din_valid && din_ready) xfer_cnt++;
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (seq_valid) begin
                obs_q.push_back({seq, last});
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            n_checks++;
            if ((last && !seq_valid) || (seq && !seq_valid)) begin
                n_fail++;
                $display("FAIL idle_outputs cyc=%0d got seq=%b last=%b seq_valid=%b want seq=0 last=0 when invalid",
                         cyc, seq, last, seq_valid);
            end
        end
    end

    // Reference model: a word expands to its normalised number of bits,
    // MSB (bit len-1) first, with last set on the final one.
    task automatic model_word(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
        int n;
        n = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back({d[i], (i == 0) ? 1'b1 : 1'b0});
        end
        exp_cnt++;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        first_v = -1;
        last_v  = -1;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; offers one word, returns at the falling
    // edge after the transfer edge. din_valid is left high for streaming.
    task automatic send_word(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
        int g = 0;
        din       = d;
        din_len   = l;
        din_valid = 1'b1;
        while (!din_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout got din_ready=%b want 1 within 200 cycles", din_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int g = 0;
        din_valid = 1'b0;
        @(negedge clk);
        while ((busy || seq_valid) && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout got busy=%b want 0 within 400 cycles", busy);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({din_ready, seq, seq_valid, last, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy/seq/sv/last/busy=%b want 10000",
                     {din_ready, seq, seq_valid, last, busy});
        end
        n_checks++;
        if (word_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_word_cnt got %0d want 0", word_cnt);
        end
        rst = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        clear_obs();
        model_word(8'hB4, 4'd8);
        send_word(8'hB4, 4'd8);          // transfer edge E
        din_valid = 1'b0;
        @(negedge clk);                  // after E+1
        n_checks++;
        if ({seq_valid, seq} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_first_bit got sv/seq=%b want 11", {seq_valid, seq});
        end
        repeat (7) @(negedge clk);       // after E+8
        n_checks++;
        if ({seq_valid, last, word_cnt} !== {2'b11, 8'(exp_cnt - 1)}) begin
            n_fail++;
            $display("FAIL single_last_bit got sv=%b last=%b cnt=%0d want sv=1 last=1 cnt=%0d",
                     seq_valid, last, word_cnt, exp_cnt - 1);
        end
        @(negedge clk);                  // after E+9
        n_checks++;
        if ({seq_valid, word_cnt} !== {1'b0, 8'(exp_cnt)}) begin
            n_fail++;
            $display("FAIL single_done got sv=%b cnt=%0d want sv=0 cnt=%0d", seq_valid, word_cnt, exp_cnt);
        end
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_len got %0d bits want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_bit%0d got {seq,last}=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_short_lengths();
        clear_obs();
        model_word(8'h05, 4'd3);
        send_word(8'h05, 4'd3);
        model_word(8'hFF, 4'd0);
        send_word(8'hFF, 4'd0);
        model_word(8'h03, 4'd12);
        send_word(8'h03, 4'd12);
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL short_len got %0d bits want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL short_bit%0d got {seq,last}=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (word_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL short_word_cnt got %0d want %0d", word_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int x0;
        clear_obs();
        x0 = xfer_cnt;
        model_word(8'hF0, 4'd8);
        send_word(8'hF0, 4'd8);
        model_word(8'h0F, 4'd8);
        send_word(8'h0F, 4'd8);
        n_checks++;
        if (din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_backpressure got din_ready=%b want 0", din_ready);
        end
        model_word(8'hAA, 4'd8);
        send_word(8'hAA, 4'd8);
        drain();
        n_checks++;
        if (obs_q.size() != 24 || exp_q.size() != 24) begin
            n_fail++;
            $display("FAIL b2b_len got %0d bits want 24", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_bit%0d got {seq,last}=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (last_v - first_v + 1 != 24) begin
            n_fail++;
            $display("FAIL b2b_contiguous got span=%0d want 24", last_v - first_v + 1);
        end
        n_checks++;
        if (xfer_cnt - x0 != 3) begin
            n_fail++;
            $display("FAIL b2b_transfers got %0d want 3", xfer_cnt - x0);
        end
        n_checks++;
        if (word_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL b2b_word_cnt got %0d want %0d", word_cnt, exp_cnt);
        end
    endtask

    task automatic test_mid_reset();
        clear_obs();
        send_word(8'hFF, 4'd8);
        send_word(8'h55, 4'd8);          // shifting with hold full
        rst = 1'b0;
        #1;
        n_checks++;
        if ({seq_valid, din_ready, busy, last} !== 4'b0100 || word_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got sv/rdy/busy/last=%b cnt=%0d want 0100 cnt=0",
                     {seq_valid, din_ready, busy, last}, word_cnt);
        end
        din_valid = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_obs();
        model_word(8'hA5, 4'd8);
        send_word(8'hA5, 4'd8);
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midreset_len got %0d bits want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midreset_bit%0d got {seq,last}=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (word_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL midreset_word_cnt got %0d want 1", word_cnt);
        end
    endtask

    task automatic test_len1_stream();
        logic [3:0] bits;
        logic [WIDTH-1:0] d;
        bits = 4'b1011;
        clear_obs();
        for (int i = 3; i >= 0; i--) begin
            d = WIDTH'($urandom);
            d[0] = bits[i];
            model_word(d, 4'd1);
            send_word(d, 4'd1);
        end
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL len1_len got %0d bits want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL len1_bit%0d got {seq,last}=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (last_v - first_v + 1 != 7) begin
            n_fail++;
            $display("FAIL len1_spacing got span=%0d want 7", last_v - first_v + 1);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        logic [LEN_W-1:0] l;
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            d = WIDTH'($urandom);
            l = LEN_W'($urandom_range(0, 15));
            model_word(d, l);
            send_word(d, l);
            if ($urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_len got %0d bits want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_bit%0d got {seq,last}=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (word_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL random_word_cnt got %0d want %0d", word_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] d;
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        clear_obs();
        for (int i = 0; i < 255; i++) begin
            d = WIDTH'($urandom);
            model_word(d, 4'd1);
            send_word(d, 4'd1);
        end
        drain();
        n_checks++;
        if (word_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_255 got %0d want 255", word_cnt);
        end
        d = WIDTH'($urandom);
        model_word(d, 4'd1);
        send_word(d, 4'd1);
        drain();
        n_checks++;
        if (word_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL wrap_0 got %0d want %0d", word_cnt, 8'(exp_cnt));
        end
        d = WIDTH'($urandom);
        model_word(d, 4'd1);
        send_word(d, 4'd1);
        drain();
        n_checks++;
        if (word_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_1 got %0d want 1", word_cnt);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_len got %0d bits want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_bit%0d got {seq,last}=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_short_lengths();
        test_back_to_back();
        test_mid_reset();
        test_len1_stream();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout got no finish want finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the serial sequence-detector FSMs. It accepts words of up to WIDTH bits over a valid/ready handshake and buffers one word. It shifts each word out MSB-first, one bit per clock, on `seq`. It flags the final bit of each word and counts completed words. `seq` feeds the detector's `seq` input directly, and `seq_valid` qualifies each bit for the detector and for the bench.

## Interface
- WIDTH, 8: maximum word width in bits (2..32).
- LEN_W, 4: width of the length field; must hold the value WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word; bits din[len-1:0] are sent.
- din_len  input  LEN_W  number of bits to send; 0 or any value > WIDTH means WIDTH.
- din_valid  input  1  producer offers din/din_len this cycle.
- din_ready  output  1  hold register empty; transfer occurs at an edge where din_valid & din_ready.
- seq  output  1  serial bit, registered.
- seq_valid  output  1  seq carries a valid bit this cycle, registered.
- last  output  1  current seq bit is the final bit of its word, registered; only high with seq_valid.
- busy  output  1  shifter active or hold register full.
- word_cnt  output  8  words fully transmitted, modulo 256.

## Operation
- Storage:
  - Hold register: one word, a flag `hold_full`, and the normalised length.
  - Shift register: WIDTH bits.
  - Bit counter: counts down the bits remaining.
- States are IDLE and SHIFT. Reset enters IDLE.
- Accept rule: `din_ready = !hold_full`, a function of register state only, with no combinational path from din_valid. On a transfer:
  - `hold_full` is set.
  - The stored data is din left-aligned: din << (WIDTH − len), so bit len-1 becomes the MSB.
- IDLE:
  - If `hold_full`: load the shifter from hold, clear `hold_full`, set the bit counter to len, and go to SHIFT.
  - Otherwise stay in IDLE.
  - A word accepted at edge E is loaded at edge E+1, never at E.
- SHIFT, on each edge, retire the current bit: shift left by 1 and decrement the counter.
- End of word: on the edge where the counter == 1 (last bit retiring):
  - `word_cnt` increments.
  - If `hold_full` was set before this edge: reload from hold and stay in SHIFT, with no gap.
  - Otherwise: go to IDLE.
- Simultaneous reload and accept:
  - On an edge where the shifter reloads from hold and din_valid is high, no transfer occurs, because din_ready was 0.
  - The new word is taken at the next edge.
- Outputs in SHIFT:
  - seq = shift[WIDTH-1].
  - seq_valid = 1.
  - last = (counter == 1).
- Outputs in IDLE: seq = 0, seq_valid = 0, last = 0.
- `word_cnt` wraps from 255 to 0 silently.
- din and din_len are ignored except on transfer edges.

## Timing
- Reset (rst low), asynchronous and immediate:
  - State = IDLE.
  - `hold_full` = 0, so din_ready = 1.
  - seq = 0, seq_valid = 0, last = 0, busy = 0, word_cnt = 0.
  - The shifter, hold register and counter are cleared.
  - A word in flight is discarded, with no partial count.
- Release: the first transfer can occur at the first rising edge after rst goes high.
- Latency: transfer at edge E into an idle block gives the first bit valid after edge E+1. The last bit of a len-bit word is valid after edge E+len. Its retiring edge is E+len+1.
- Throughput:
  - With len ≥ 2 and the producer keeping din_valid high, consecutive words stream with seq_valid continuously high.
  - With len = 1 on every word, one bit every 2 cycles. seq_valid toggles, because hold refills one edge after it empties.
- busy = (state == SHIFT) | hold_full.

## Test plan
- Reset: assert rst low mid-SHIFT with hold full → same cycle seq_valid=0, din_ready=1, word_cnt=0. After release, a fresh word 8'hA5 (len 8) → 1,0,1,0,0,1,0,1.
- Single word: din=8'hB4, din_len=8 at edge E → seq 1,0,1,1,0,1,0,0 on cycles E+1..E+8. last only on the 8th bit; word_cnt 0→1 at edge E+9; seq_valid=0 afterwards.
- Short and zero length:
  - din=8'h05, len=3 → 1,0,1 with last on the 3rd bit.
  - din=8'hFF, len=0 → eight 1s.
  - din=8'h03, len=12 → treated as 8 → 0,0,0,0,0,0,1,1.
- Back-to-back with backpressure:
  - Drive 8'hF0, 8'h0F, 8'hAA with din_valid held high.
  - Required: 24 contiguous valid bits 11110000 00001111 10101010; din_ready low whenever hold is full; each word accepted exactly once; word_cnt=3.
- len=1 stream: words with bits 1,0,1,1 → seq_valid pattern 1,0,1,0,1,0,1 with data 1,0,1,1; last high on every valid bit.
- Counter wrap: send 257 words of len 1 → word_cnt reads 1 at the end, having passed 255→0.
